// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared types and defaults for RAM port-B streaming
package ram_stream_pkg;

  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO with flush and occupancy count
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; flush drops contents but keeps stale data words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_b_streamer.sv
// rtl/ram_b_streamer.sv - streams a contiguous byte range from RAM port B
module ram_b_streamer
  import ram_stream_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  localparam int LW  = ADDR_W + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  stream_state_e     state_q, state_d;
  logic [ADDR_W-1:0] address_b_q, address_b_d;
  logic [LW-1:0]     remain_q, remain_d;
  logic              done_q, done_d;
  // Bit 0 marks a read whose address sits in address_b this cycle; bit RD_LAT
  // marks the cycle its data is present on q_b.
  logic [RD_LAT:0]   inflight_q, inflight_d;

  logic              issue;
  logic              flush;
  logic              can_issue;
  logic [OCW-1:0]    occ;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign fifo_push = inflight_q[RD_LAT] && !fifo_full;
  assign fifo_pop  = !fifo_empty && m_ready;

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign address_b = address_b_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_head;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (q_b),
    .pop       (fifo_pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Credit: everything already buffered or on its way, net of this cycle's pop, must leave room.
  always_comb begin
    occ = OCW'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCW'(inflight_q[i]);
    end
    occ = occ + OCW'(fifo_push);
    if (fifo_pop) begin
      occ = occ - OCW'(1);
    end
    can_issue = (occ < OCW'(FIFO_DEPTH));
  end

  // Next-state logic: the first read issues on the start cycle itself so address_b is live in cycle 1.
  always_comb begin
    state_d     = state_q;
    address_b_d = address_b_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            issue       = 1'b1;
            address_b_d = base_addr;
            remain_d    = length - LW'(1);
            state_d     = (length == LW'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (can_issue) begin
          issue       = 1'b1;
          address_b_d = address_b_q + 1'b1;
          remain_d    = remain_q - LW'(1);
          if (remain_q == LW'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (fifo_pop && (fifo_count == FCW'(1)) && (inflight_q == '0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      inflight_d = '0;
    end else begin
      inflight_d = {inflight_q[RD_LAT-1:0], issue};
    end
  end

  // State, address, count and in-flight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      address_b_q <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      address_b_q <= address_b_d;
      remain_q    <= remain_d;
      done_q      <= done_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ram_b_streamer.sv
// tb/tb_ram_b_streamer.sv - directed self-checking bench for ram_b_streamer
module tb_ram_b_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        abort, abort2;
  logic        busy, busy2;
  logic        done, done2;
  logic [10:0] address_b, address_b2;
  logic [7:0]  q_b, q_b2, q2_s1;
  logic        m_valid, m_valid2;
  logic [7:0]  m_data, m_data2;
  logic        m_ready, m_ready2;

  logic [7:0]  mem [2048];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_b_streamer #(.ADDR_W(11), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .address_b(address_b), .q_b(q_b),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  ram_b_streamer #(.ADDR_W(11), .DATA_W(8), .RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr), .length(length),
    .abort(abort2), .busy(busy2), .done(done2), .address_b(address_b2), .q_b(q_b2),
    .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2)
  );

  // RAM port B models: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    q_b   <= mem[address_b];
    q2_s1 <= mem[address_b2];
    q_b2  <= q2_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept bytes with m_ready high until done, expecting first, first+1, ...
  task automatic collect(input string tag, input logic [7:0] first, input int n);
    int  k;
    bit  seen;
    k    = 0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (m_valid && m_ready) begin
          chk({tag, "_data"}, {24'd0, m_data}, first + k);
          k++;
        end
        tick();
      end
    end
    chk({tag, "_count"}, k, n);
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[11'h010] = 8'hA0; mem[11'h011] = 8'hA1; mem[11'h012] = 8'hA2; mem[11'h013] = 8'hA3;
    mem[11'h7FE] = 8'h11; mem[11'h7FF] = 8'h22; mem[11'h000] = 8'h33; mem[11'h001] = 8'h44;
    for (int i = 0; i < 5; i++) begin
      mem[11'h100 + i] = 8'hB0 + 8'(i);
    end
    mem[11'h300] = 8'hC0; mem[11'h301] = 8'hC1;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; abort2 = 1'b0;
    base_addr = '0; length = '0; m_ready = 1'b0; m_ready2 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_addr", {21'd0, address_b}, 0);

    // Basic run, RD_LAT=1
    base_addr = 11'h010; length = 12'd4; m_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_c1_busy", {31'd0, busy}, 1);
    chk("t1_c1_addr", {21'd0, address_b}, 32'h010);
    chk("t1_c1_valid", {31'd0, m_valid}, 0);
    tick();
    chk("t1_c2_addr", {21'd0, address_b}, 32'h011);
    chk("t1_c2_valid", {31'd0, m_valid}, 0);
    tick();
    chk("t1_c3_addr", {21'd0, address_b}, 32'h012);
    chk("t1_c3_valid", {31'd0, m_valid}, 1);
    chk("t1_c3_data", {24'd0, m_data}, 32'hA0);
    tick();
    chk("t1_c4_addr", {21'd0, address_b}, 32'h013);
    chk("t1_c4_data", {24'd0, m_data}, 32'hA1);
    tick();
    chk("t1_c5_addr", {21'd0, address_b}, 32'h013);
    chk("t1_c5_data", {24'd0, m_data}, 32'hA2);
    tick();
    chk("t1_c6_data", {24'd0, m_data}, 32'hA3);
    chk("t1_c6_done", {31'd0, done}, 0);
    tick();
    chk("t1_c7_done", {31'd0, done}, 1);
    chk("t1_c7_busy", {31'd0, busy}, 0);
    chk("t1_c7_valid", {31'd0, m_valid}, 0);

    // Address wrap
    base_addr = 11'h7FE; length = 12'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_done_clear", {31'd0, done}, 0);
    chk("t2_c1_addr", {21'd0, address_b}, 32'h7FE);
    tick();
    chk("t2_c2_addr", {21'd0, address_b}, 32'h7FF);
    tick();
    chk("t2_c3_addr", {21'd0, address_b}, 32'h000);
    chk("t2_c3_data", {24'd0, m_data}, 32'h11);
    tick();
    chk("t2_c4_addr", {21'd0, address_b}, 32'h001);
    chk("t2_c4_data", {24'd0, m_data}, 32'h22);
    tick();
    chk("t2_c5_data", {24'd0, m_data}, 32'h33);
    tick();
    chk("t2_c6_data", {24'd0, m_data}, 32'h44);
    tick();
    chk("t2_c7_done", {31'd0, done}, 1);

    // Back-pressure, plus a start while busy that must be ignored
    base_addr = 11'h100; length = 12'd5; m_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t3_c4_addr", {21'd0, address_b}, 32'h103);
    base_addr = 11'h700; length = 12'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t3_c10_addr", {21'd0, address_b}, 32'h103);
    chk("t3_c10_valid", {31'd0, m_valid}, 1);
    chk("t3_c10_data", {24'd0, m_data}, 32'hB0);
    chk("t3_c10_busy", {31'd0, busy}, 1);
    tick();
    m_ready = 1'b1;
    collect("t3", 8'hB0, 5);

    // Zero length
    base_addr = 11'h555; length = 12'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_valid", {31'd0, m_valid}, 0);
    chk("t4_addr", {21'd0, address_b}, 32'h104);
    tick();
    chk("t4_done_clear", {31'd0, done}, 0);

    // Abort two cycles after first m_valid
    base_addr = 11'h200; length = 12'd16; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t5_c3_valid", {31'd0, m_valid}, 1);
    chk("t5_c3_data", {24'd0, m_data}, 32'h5A);
    tick(); tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t5_c6_valid", {31'd0, m_valid}, 0);
    chk("t5_c6_busy", {31'd0, busy}, 0);
    chk("t5_c6_done", {31'd0, done}, 0);
    tick();
    chk("t5_c7_valid", {31'd0, m_valid}, 0);
    chk("t5_c7_done", {31'd0, done}, 0);
    base_addr = 11'h300; length = 12'd2; start = 1'b1;
    tick(); start = 1'b0;
    collect("t5_post", 8'hC0, 2);

    // RD_LAT=2 instance, basic run
    base_addr = 11'h010; length = 12'd4; m_ready2 = 1'b1; start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("t6_c1_addr", {21'd0, address_b2}, 32'h010);
    chk("t6_c1_busy", {31'd0, busy2}, 1);
    tick(); tick();
    chk("t6_c3_valid", {31'd0, m_valid2}, 0);
    tick();
    chk("t6_c4_valid", {31'd0, m_valid2}, 1);
    chk("t6_c4_data", {24'd0, m_data2}, 32'hA0);
    tick();
    chk("t6_c5_data", {24'd0, m_data2}, 32'hA1);
    tick();
    chk("t6_c6_data", {24'd0, m_data2}, 32'hA2);
    tick();
    chk("t6_c7_data", {24'd0, m_data2}, 32'hA3);
    tick();
    chk("t6_c8_done", {31'd0, done2}, 1);
    chk("t6_c8_busy", {31'd0, busy2}, 0);

    // Reset in the middle of a transfer
    base_addr = 11'h010; length = 12'd16; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t7_busy", {31'd0, busy}, 0);
    chk("t7_valid", {31'd0, m_valid}, 0);
    chk("t7_addr", {21'd0, address_b}, 0);
    chk("t7_done", {31'd0, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_b_streamer.md
# ram_b_streamer

Sequential reader for the otherwise idle second port of the dual-port data RAM. On a start command it reads a contiguous byte range through port B and delivers it, one byte per transfer, on a valid/ready stream toward an output peripheral (UART or display). The processor keeps exclusive use of port A. A small internal FIFO absorbs the RAM read latency and any downstream back-pressure.

## Interface
- ADDR_W, 11, port-B address width (bytes)
- DATA_W, 8, port-B data width
- RD_LAT, 1, RAM port-B read latency in cycles (address to q_b); legal values 1 or 2
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least RD_LAT+2

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address, captured with start
- length  in  ADDR_W+1  byte count 0..2^ADDR_W, captured with start
- abort  in  1  cancel the current transfer
- busy  out  1  high while a transfer is active
- done  out  1  one-cycle pulse when a transfer completes normally
- address_b  out  ADDR_W  registered RAM port-B address
- q_b  in  DATA_W  RAM port-B read data
- m_valid  out  1  stream data valid
- m_data  out  DATA_W  stream byte
- m_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with length>0: capture base_addr and length, then go to RUN.
  - start=1 with length=0: no reads issued; done pulses the next cycle; stay in IDLE.
- RUN:
  - Issue one read per cycle while the credit holds: fifo_count + inflight + (write this cycle ? 1 : 0) - (pop this cycle ? 1 : 0) < FIFO_DEPTH.
  - Each issue drives address_b to the next address, increments the address modulo 2^ADDR_W (wraps 0x7FF to 0x000), and decrements the remaining-issue count.
  - Go to DRAIN when the last read is issued.
- DRAIN: no further issues. Return to IDLE after the final byte handshake (m_valid && m_ready) with an empty FIFO and inflight=0.
- In-flight tracking: a RD_LAT-deep valid shift register. When its tail is set, q_b is written into the FIFO. The FIFO never overflows, by construction of the credit rule.
- Stream rules:
  - m_valid = FIFO not empty.
  - m_data = FIFO head.
  - Once m_valid is asserted it stays high, with m_data stable, until m_ready.
- start while busy is ignored.
- abort in RUN or DRAIN:
  - Next cycle: IDLE, FIFO flushed, in-flight valid bits cleared (late q_b discarded), m_valid=0, busy=0.
  - done is not pulsed.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Reset values: busy=0, done=0, m_valid=0, m_data=0, address_b=0, FSM=IDLE, FIFO empty.
- address_b holds its last value when not issuing.

## Timing
- start accepted in cycle 0:
  - busy=1 and address_b=base_addr in cycle 1.
  - q_b valid in cycle 1+RD_LAT.
  - FIFO write at the end of that cycle.
  - First m_valid in cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
- With m_ready held high, throughput is one byte per cycle with no bubbles (requires FIFO_DEPTH ≥ RD_LAT+2).
- Final handshake in cycle k: done=1 and busy=0 in cycle k+1. A new start is accepted in cycle k+1.
- Back-pressure: while m_ready=0 the FIFO fills, issuing stalls after at most FIFO_DEPTH outstanding bytes, and address_b freezes.
- Reset mid-transfer overrides everything; the next cycle is in reset state.

## Structure
- Package ram_stream_pkg:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Default ADDR_W, DATA_W, RD_LAT constants.
  - Shared with the future port-B consumers.
- Sub-module stream_fifo:
  - Synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Instantiated once for the output buffer.
- Top level holds the FSM, address/count registers, in-flight shift register, and credit logic.

## Test plan
- base_addr=0x010, length=4, m_ready=1, RAM holding 0xA0..0xA3 at 0x010..0x013 → address_b 0x010..0x013 in cycles 1..4; m_data A0,A1,A2,A3 on cycles 3..6; done in cycle 7.
- base_addr=0x7FE, length=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001; bytes delivered in that order.
- length=5 with m_ready low for 10 cycles after start → at most FIFO_DEPTH reads issued before the stall; all 5 bytes delivered in order once m_ready rises; no loss or duplication.
- length=0 → done one cycle after start; busy, m_valid, and address_b unchanged.
- abort two cycles after the first m_valid on a length=16 run → next cycle m_valid=0, busy=0, no done; a following start with length=2 delivers exactly the 2 new bytes.
- Repeat the first scenario with RD_LAT=2 → first m_valid in cycle 4; still one byte per cycle.
